// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax sequencer: sizes, fp16 constants,
// the sequencer state type and the fp16 total-order key.
package softmax_pkg;

  localparam int DATAWIDTH = 16;
  localparam int NUM       = 4;
  localparam int ADDRW     = 8;

  localparam logic [15:0] NEG_INF = 16'hFC00;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_MAX       = 4'd1,
    ST_SUM_RD    = 4'd2,
    ST_SUM_ISSUE = 4'd3,
    ST_SUM_WAIT  = 4'd4,
    ST_NRM_RD    = 4'd5,
    ST_NRM_ISSUE = 4'd6,
    ST_NRM_WAIT  = 4'd7,
    ST_FIN       = 4'd8
  } state_t;

  // Maps an fp16 value onto an unsigned key whose ordering matches the
  // numeric ordering (with -0 below +0); NaN is not expected.
  function automatic logic [15:0] fp16_key(input logic [15:0] x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

endpackage

// File: rtl/fp16_max4.sv
// Combinational max of a running fp16 maximum against one chunk of lanes.
module fp16_max4
  import softmax_pkg::*;
(
  input  logic [DATAWIDTH-1:0]     i_max,
  input  logic [DATAWIDTH*NUM-1:0] i_lanes,
  output logic [DATAWIDTH-1:0]     o_max
);

  // Fold each lane into the running max using the key ordering
  always_comb begin
    o_max = i_max;
    for (int unsigned l = 0; l < NUM; l++) begin
      if (fp16_key(i_lanes[l*DATAWIDTH +: DATAWIDTH]) > fp16_key(o_max)) begin
        o_max = i_lanes[l*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Sequencer driving the 4-lane fp16 softmax datapath over a multi-chunk
// vector: global max scan, exp-sum pass, normalize pass with write-back.
module softmax_seq_ctrl #(
  parameter int DATAWIDTH = softmax_pkg::DATAWIDTH,
  parameter int NUM       = softmax_pkg::NUM,
  parameter int ADDRW     = softmax_pkg::ADDRW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRW-1:0]         base_addr,
  input  logic [ADDRW-1:0]         out_addr,
  input  logic [ADDRW-1:0]         len,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDRW-1:0]         rd_addr,
  input  logic [DATAWIDTH*NUM-1:0] rd_data,
  output logic                     dp_start,
  output logic                     dp_phase,
  output logic                     dp_clear,
  output logic [DATAWIDTH*NUM-1:0] dp_inp,
  output logic [DATAWIDTH-1:0]     dp_max,
  input  logic                     dp_done,
  input  logic [DATAWIDTH*NUM-1:0] dp_outp,
  output logic                     wr_en,
  output logic [ADDRW-1:0]         wr_addr,
  output logic [DATAWIDTH*NUM-1:0] wr_data
);

  import softmax_pkg::*;

  state_t                   r_state;
  logic [ADDRW-1:0]         r_base;
  logic [ADDRW-1:0]         r_out;
  logic [ADDRW-1:0]         r_len;
  logic [ADDRW-1:0]         r_cnt;
  logic                     r_rv;
  logic                     r_done;
  logic [DATAWIDTH-1:0]     r_max;
  logic [DATAWIDTH*NUM-1:0] r_inp;

  logic [DATAWIDTH-1:0]     w_max_next;
  logic                     w_last;
  logic                     w_max_issue;

  fp16_max4 u_max (
    .i_max   (r_max),
    .i_lanes (rd_data),
    .o_max   (w_max_next)
  );

  // Chunk counter reaching the final chunk of a SUM/NRM pass
  assign w_last      = ((r_cnt + ADDRW'(1)) == r_len);
  // During the max scan, reads are issued until all chunks are requested
  assign w_max_issue = (r_state == ST_MAX) && (r_cnt != r_len);

  // Output decode from the current state and registers
  always_comb begin
    busy     = (r_state != ST_IDLE);
    done     = r_done;
    rd_en    = w_max_issue || (r_state == ST_SUM_RD) || (r_state == ST_NRM_RD);
    rd_addr  = rd_en ? (r_base + r_cnt) : '0;
    dp_start = (r_state == ST_SUM_ISSUE) || (r_state == ST_NRM_ISSUE);
    dp_phase = (r_state == ST_NRM_RD) || (r_state == ST_NRM_ISSUE) ||
               (r_state == ST_NRM_WAIT);
    dp_clear = (r_state == ST_SUM_ISSUE) && (r_cnt == '0);
    // The chunk is forwarded straight from the SRAM in the issue cycle so
    // the kick and its data line up; the register holds it afterwards.
    dp_inp   = dp_start ? rd_data : r_inp;
    dp_max   = r_max;
    wr_en    = (r_state == ST_NRM_WAIT) && dp_done;
    wr_addr  = wr_en ? (r_out + r_cnt) : '0;
    wr_data  = wr_en ? dp_outp : '0;
  end

  // Sequencer FSM, chunk counter and job registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_base  <= '0;
      r_out   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_rv    <= 1'b0;
      r_done  <= 1'b0;
      r_max   <= NEG_INF;
      r_inp   <= '0;
    end else begin
      r_done <= 1'b0;
      r_rv   <= w_max_issue;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base <= base_addr;
            r_out  <= out_addr;
            r_len  <= len;
            r_cnt  <= '0;
            if (len == '0) begin
              r_state <= ST_FIN;
            end else begin
              r_max   <= NEG_INF;
              r_state <= ST_MAX;
            end
          end
        end
        ST_MAX: begin
          if (r_rv) begin
            r_max <= w_max_next;
          end
          // Once every read is issued, this cycle carries the last return
          if (r_cnt == r_len) begin
            r_cnt   <= '0;
            r_state <= ST_SUM_RD;
          end else begin
            r_cnt <= r_cnt + ADDRW'(1);
          end
        end
        ST_SUM_RD: begin
          r_state <= ST_SUM_ISSUE;
        end
        ST_SUM_ISSUE: begin
          r_inp   <= rd_data;
          r_state <= ST_SUM_WAIT;
        end
        ST_SUM_WAIT: begin
          if (dp_done) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= ST_NRM_RD;
            end else begin
              r_cnt   <= r_cnt + ADDRW'(1);
              r_state <= ST_SUM_RD;
            end
          end
        end
        ST_NRM_RD: begin
          r_state <= ST_NRM_ISSUE;
        end
        ST_NRM_ISSUE: begin
          r_inp   <= rd_data;
          r_state <= ST_NRM_WAIT;
        end
        ST_NRM_WAIT: begin
          if (dp_done) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= ST_FIN;
            end else begin
              r_cnt   <= r_cnt + ADDRW'(1);
              r_state <= ST_NRM_RD;
            end
          end
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Scoreboard bench for softmax_seq_ctrl with SRAM and datapath models.
module tb_softmax_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  out_addr = '0;
  logic [7:0]  len = '0;
  logic        busy, done, rd_en, dp_start, dp_phase, dp_clear, wr_en;
  logic [7:0]  rd_addr, wr_addr;
  logic [63:0] rd_data = '0;
  logic [63:0] dp_inp, wr_data;
  logic [63:0] dp_outp = '0;
  logic [15:0] dp_max;
  logic        dp_done_m = 1'b0;
  logic        inj_done = 1'b0;
  logic        dp_done;

  assign dp_done = dp_done_m | inj_done;

  softmax_seq_ctrl #(.DATAWIDTH(16), .NUM(4), .ADDRW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .out_addr(out_addr), .len(len), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .dp_start(dp_start), .dp_phase(dp_phase), .dp_clear(dp_clear),
    .dp_inp(dp_inp), .dp_max(dp_max), .dp_done(dp_done),
    .dp_outp(dp_outp), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM: data one cycle after the read strobe
  logic [63:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Datapath model: done D cycles after the kick, output tags input with max
  int dp_lat = 3;
  int cnt_m = 0;
  logic [63:0] cap = '0;
  always @(posedge clk) begin
    dp_done_m <= 1'b0;
    if (!reset) cnt_m <= 0;
    else if (dp_start) begin
      cap   <= dp_inp;
      cnt_m <= dp_lat - 1;
    end else if (cnt_m > 0) begin
      cnt_m <= cnt_m - 1;
      if (cnt_m == 1) begin
        dp_done_m <= 1'b1;
        dp_outp   <= cap ^ {4{dp_max}};
      end
    end
  end

  typedef struct { logic [7:0] addr; logic [63:0] data; } wr_t;
  typedef struct { logic phase; logic clr; logic [63:0] inp; } st_t;
  typedef struct { int unsigned cyc; logic [15:0] mx; } dn_t;
  wr_t        q_wr[$];
  logic [7:0] q_rd[$];
  st_t        q_st[$];
  dn_t        q_dn[$];

  int n_tests = 0;
  int n_fail = 0;
  int n_dpstart = 0;
  logic [15:0] exp_max_hold = 16'hFC00;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen with nothing expected", nm);
  endtask

  // fp16 -> real; infinities map beyond the finite range
  function automatic real h2r(input logic [15:0] h);
    real v;
    int e, sh;
    e = int'(h[14:10]);
    if (e == 31) v = 1.0e10;
    else begin
      v  = (e == 0) ? real'(int'(h[9:0])) : real'(1024 + int'(h[9:0]));
      sh = (e == 0) ? -24 : e - 25;
      for (int k = 0; k < sh; k++) v = v * 2.0;
      for (int k = 0; k < -sh; k++) v = v / 2.0;
    end
    return h[15] ? -v : v;
  endfunction

  function automatic bit fp_gt(input logic [15:0] a, input logic [15:0] b);
    real ra, rb;
    ra = h2r(a);
    rb = h2r(b);
    return (ra > rb) || (ra == rb && !a[15] && b[15]);
  endfunction

  function automatic logic [15:0] ref_max(input logic [7:0] b, input int l);
    logic [15:0] m;
    logic [63:0] ch;
    m = 16'hFC00;
    for (int i = 0; i < l; i++) begin
      ch = mem[8'(b + 8'(i))];
      for (int j = 0; j < 4; j++)
        if (fp_gt(ch[16*j +: 16], m)) m = ch[16*j +: 16];
    end
    return m;
  endfunction

  function automatic logic [15:0] rnd_h();
    logic [15:0] h;
    h = 16'($urandom);
    if (h[14:10] == 5'h1f) h[9:0] = '0;
    return h;
  endfunction

  // Monitor: pop expectations whenever the DUT presents an event
  wr_t m_wr;
  st_t m_st;
  dn_t m_dn;
  logic [7:0] m_rd;
  always @(negedge clk) begin
    if (reset) begin
      if (rd_en) begin
        if (q_rd.size() == 0) unexp("rd_en");
        else begin m_rd = q_rd.pop_front(); chk("rd_addr", rd_addr, m_rd); end
      end
      if (dp_start) begin
        n_dpstart++;
        if (q_st.size() == 0) unexp("dp_start");
        else begin
          m_st = q_st.pop_front();
          chk("dp_phase", dp_phase, m_st.phase);
          chk("dp_clear", dp_clear, m_st.clr);
          chk("dp_inp", dp_inp, m_st.inp);
        end
      end
      if (wr_en) begin
        if (q_wr.size() == 0) unexp("wr_en");
        else begin
          m_wr = q_wr.pop_front();
          chk("wr_addr", wr_addr, m_wr.addr);
          chk("wr_data", wr_data, m_wr.data);
        end
      end
      if (done) begin
        if (q_dn.size() == 0) unexp("done");
        else begin
          m_dn = q_dn.pop_front();
          chk("done_cycle", cyc, m_dn.cyc);
          chk("dp_max", dp_max, m_dn.mx);
          chk("writes_left", q_wr.size(), 0);
          chk("reads_left", q_rd.size(), 0);
          chk("starts_left", q_st.size(), 0);
        end
      end
    end
  end

  task automatic flush();
    q_wr.delete(); q_rd.delete(); q_st.delete(); q_dn.delete();
  endtask

  // Called at a negedge: queue the expected job behaviour, then pulse start
  task automatic start_job(input logic [7:0] b, input logic [7:0] o,
                           input logic [7:0] l, input int d);
    logic [15:0] mx;
    int li;
    li = int'(l);
    dp_lat = d;
    mx = (li != 0) ? ref_max(b, li) : exp_max_hold;
    exp_max_hold = mx;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < li; i++) q_rd.push_back(b + 8'(i));
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < li; i++)
        q_st.push_back('{phase: p[0], clr: (p == 0 && i == 0), inp: mem[8'(b + 8'(i))]});
    for (int i = 0; i < li; i++)
      q_wr.push_back('{addr: o + 8'(i), data: mem[8'(b + 8'(i))] ^ {4{mx}}});
    q_dn.push_back('{cyc: cyc + ((li == 0) ? 2 : 3 + li + 2 * li * (2 + d)), mx: mx});
    base_addr = b; out_addr = o; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int maxcyc, input bit glitch);
    int k;
    bit injected;
    k = 0;
    injected = 1'b0;
    while (q_dn.size() != 0 && k < maxcyc) begin
      @(negedge clk);
      k++;
      inj_done = 1'b0;
      if (glitch) begin
        if (k == 3) begin base_addr = 8'hA0; len = 8'd7; start = 1'b1; end
        if (k == 4) start = 1'b0;
        if (!injected && n_dpstart >= 1 && rd_en && !dp_phase && !dp_start) begin
          inj_done = 1'b1;
          injected = 1'b1;
        end
      end
    end
    start = 1'b0;
    inj_done = 1'b0;
    if (q_dn.size() != 0) begin
      unexp("job_timeout");
      flush();
    end
    if (glitch) chk("glitch_injected", injected, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_dp_start"}, dp_start, 0);
    chk({tag, "_dp_phase"}, dp_phase, 0);
    chk({tag, "_dp_clear"}, dp_clear, 0);
    chk({tag, "_dp_inp"}, dp_inp, 0);
    chk({tag, "_dp_max"}, dp_max, 16'hFC00);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit hit;
    int k;
    for (int a = 0; a < 256; a++) mem[a] = {rnd_h(), rnd_h(), rnd_h(), rnd_h()};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single-chunk reference vector
    mem[8'h10] = {16'h993e, 16'h4210, 16'h4040, 16'h3800};
    start_job(8'h10, 8'h20, 8'd1, 5);
    wait_done(200, 1'b0);

    // Max in chunk 2 lane 3, everything else negative
    for (int i = 0; i < 3; i++)
      mem[8'h30 + 8'(i)] = {rnd_h() | 16'h8000, rnd_h() | 16'h8000,
                            rnd_h() | 16'h8000, rnd_h() | 16'h8000};
    mem[8'h32][63:48] = 16'h4210;
    start_job(8'h30, 8'h60, 8'd3, 4);
    wait_done(300, 1'b0);

    // Empty job
    start_job(8'h05, 8'h06, 8'd0, 3);
    wait_done(20, 1'b0);

    // Signed zeros with address wrap
    mem[8'hFF] = {16'h8000, 16'h0000, 16'h8000, 16'h8000};
    mem[8'h00] = {16'h8000, 16'h8000, 16'h0000, 16'h8000};
    start_job(8'hFF, 8'h80, 8'd2, 3);
    wait_done(200, 1'b0);

    // Randomized jobs
    for (int t = 0; t < 8; t++) begin
      start_job(8'($urandom), 8'($urandom), 8'($urandom_range(1, 8)),
                int'($urandom_range(2, 6)));
      wait_done(400, 1'b0);
    end

    // Start while busy and stray dp_done outside a wait state
    start_job(8'h40, 8'h90, 8'd4, 3);
    wait_done(500, 1'b1);

    // Reset during the normalize wait, then a fresh job
    start_job(8'h50, 8'hC0, 8'd3, 4);
    hit = 1'b0;
    k = 0;
    while (!hit && k < 300) begin
      @(negedge clk);
      k++;
      if (dp_phase && !rd_en && !dp_start && !wr_en) hit = 1'b1;
    end
    chk("reached_nrm_wait", hit, 1'b1);
    reset = 1'b0;
    flush();
    @(negedge clk);
    reset = 1'b1;
    chk_idle_outputs("abort");
    exp_max_hold = 16'hFC00;
    repeat (10) @(negedge clk);
    start_job(8'h50, 8'hC0, 8'd3, 4);
    wait_done(300, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
